// File: rtl/acc_issue_if.sv
// Bundle of the job, partial-sum and command signals of the issue sequencer.
// The master side is whatever launches jobs, feeds partial sums and watches
// the command stream. The slave side is the issuer itself.
interface acc_issue_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 8
);
    // Job control
    logic              start;
    logic [CNT_W-1:0]  acc_len;
    logic [CNT_W-1:0]  num_out;
    logic              busy;
    logic              done;

    // Partial-sum stream from the compute array
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;

    // Command stream to the output accumulator
    logic [2:0]        sig;
    logic [DATA_W-1:0] data;
    logic              isStop;

    modport master (
        output start, acc_len, num_out, in_valid, in_data,
        input  in_ready, sig, data, isStop, busy, done
    );

    modport slave (
        input  start, acc_len, num_out, in_valid, in_data,
        output in_ready, sig, data, isStop, busy, done
    );
endinterface

// File: rtl/acc_issue.sv
// Issue sequencer for the output accumulator.
// A job produces num_out result words, each framed as CLR followed by acc_len
// ACC commands and closed by OUT; the whole job is bracketed by CAT_START and
// CAT_END. Partial sums arrive over a valid/ready handshake and are forwarded
// unchanged as the ACC operand. All command outputs are registered, so a
// command appears on sig the cycle after the state that issues it.
module acc_issue #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 8
) (
    input  logic        clk,
    input  logic        rst,
    acc_issue_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CATS = 3'd1,
        ST_CLR  = 3'd2,
        ST_ACC  = 3'd3,
        ST_OUT  = 3'd4,
        ST_END  = 3'd5,
        ST_DONE = 3'd6
    } state_e;

    typedef enum logic [2:0] {
        CMD_NOP       = 3'b000,
        CMD_ACC       = 3'b001,
        CMD_OUT       = 3'b010,
        CMD_CAT_START = 3'b011,
        CMD_CAT_END   = 3'b100,
        CMD_CLR       = 3'b101
    } cmd_e;

    state_e            state_q,   state_d;
    logic [CNT_W-1:0]  acc_len_q, acc_len_d;
    logic [CNT_W-1:0]  num_out_q, num_out_d;
    logic [CNT_W-1:0]  sum_cnt_q, sum_cnt_d;
    logic [CNT_W-1:0]  out_cnt_q, out_cnt_d;
    cmd_e              sig_q,     sig_d;
    logic [DATA_W-1:0] data_q,    data_d;
    logic              is_stop_q, is_stop_d;
    logic              busy_q,    busy_d;
    logic              done_q,    done_d;

    logic              handshake;
    logic [CNT_W-1:0]  sum_last;
    logic [CNT_W-1:0]  out_cnt_inc;

    // The issuer only takes partial sums while it is accumulating a word.
    assign bus.in_ready = (state_q == ST_ACC);
    assign handshake    = bus.in_valid && bus.in_ready;

    // Index of the final partial sum of a word. Only used in ACC, where
    // acc_len is known to be non-zero, so the decrement never underflows and
    // acc_len = 2^CNT_W-1 needs no extra counter bit.
    assign sum_last    = acc_len_q - 1'b1;
    assign out_cnt_inc = out_cnt_q + 1'b1;

    // Next-state, counter and command decode for the issue sequence.
    always_comb begin
        // NOTE: every signal gets a default here so no path leaves one unassigned and infers a latch.
        state_d   = state_q;
        acc_len_d = acc_len_q;
        num_out_d = num_out_q;
        sum_cnt_d = sum_cnt_q;
        out_cnt_d = out_cnt_q;
        sig_d     = CMD_NOP;
        data_d    = '0;
        is_stop_d = 1'b0;
        busy_d    = busy_q;
        done_d    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    acc_len_d = bus.acc_len;
                    num_out_d = bus.num_out;
                    sum_cnt_d = '0;
                    out_cnt_d = '0;
                    busy_d    = 1'b1;
                    state_d   = (bus.num_out == '0) ? ST_END : ST_CATS;
                end
            end

            ST_CATS: begin
                sig_d   = CMD_CAT_START;
                state_d = (acc_len_q == '0) ? ST_OUT : ST_CLR;
            end

            ST_CLR: begin
                sig_d     = CMD_CLR;
                sum_cnt_d = '0;
                state_d   = ST_ACC;
            end

            ST_ACC: begin
                // A stalled cycle falls through to the NOP defaults.
                if (handshake) begin
                    sig_d     = CMD_ACC;
                    data_d    = bus.in_data;
                    sum_cnt_d = sum_cnt_q + 1'b1;
                    if (sum_cnt_q == sum_last) begin
                        state_d = ST_OUT;
                    end
                end
            end

            ST_OUT: begin
                sig_d     = CMD_OUT;
                out_cnt_d = out_cnt_inc;
                if (out_cnt_inc == num_out_q) begin
                    state_d = ST_END;
                end else if (acc_len_q == '0) begin
                    // Zero-length words are just back-to-back OUT commands.
                    state_d = ST_OUT;
                end else begin
                    state_d = ST_CLR;
                end
            end

            ST_END: begin
                sig_d     = CMD_CAT_END;
                is_stop_d = 1'b1;
                state_d   = ST_DONE;
            end

            ST_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, latched job parameters, counters and registered outputs.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only; reset is synchronous and clears every flop.
        if (!rst) begin
            state_q   <= ST_IDLE;
            acc_len_q <= '0;
            num_out_q <= '0;
            sum_cnt_q <= '0;
            out_cnt_q <= '0;
            sig_q     <= CMD_NOP;
            data_q    <= '0;
            is_stop_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_len_q <= acc_len_d;
            num_out_q <= num_out_d;
            sum_cnt_q <= sum_cnt_d;
            out_cnt_q <= out_cnt_d;
            sig_q     <= sig_d;
            data_q    <= data_d;
            is_stop_q <= is_stop_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.sig    = sig_q;
    assign bus.data   = data_q;
    assign bus.isStop = is_stop_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;

endmodule

// File: tb/tb_acc_issue.sv
// Directed bench for acc_issue. Each job is logged cycle by cycle, sampled
// 1ns after the rising edge; log index 0 is the cycle right after the edge
// that accepted start. Expected command streams are written out by hand.
module tb_acc_issue;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    acc_issue_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    acc_issue #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int assertions = 0;
    int failures   = 0;

    logic [2:0]  sig_log  [$];
    logic [31:0] data_log [$];
    logic        stop_log [$];
    logic        busy_log [$];
    logic        done_log [$];
    logic        rdy_log  [$];

    // Observed tuple {sig, isStop, busy, done, data} for log index i.
    function automatic logic [37:0] obs(input int i);
        return {sig_log[i], stop_log[i], busy_log[i], done_log[i], data_log[i]};
    endfunction

    // Expected tuple for a job whose log is len entries long: busy is high
    // until the last entry, done only on the last, isStop only with 100.
    function automatic logic [37:0] want(input int s, input int i, input int len,
                                         input logic [31:0] d);
        logic [2:0] sv;
        sv = s[2:0];
        return {sv, (sv == 3'b100), (i < len - 1), (i == len - 1), d};
    endfunction

    function automatic string fmt(input logic [37:0] t);
        return $sformatf("sig=%0d stop=%0b busy=%0b done=%0b data=%0h",
                         t[37:35], t[34], t[33], t[32], t[31:0]);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        sig_log.push_back(bus.sig);
        data_log.push_back(bus.data);
        stop_log.push_back(bus.isStop);
        busy_log.push_back(bus.busy);
        done_log.push_back(bus.done);
        rdy_log.push_back(bus.in_ready);
    endtask

    task automatic clear_logs();
        sig_log.delete();
        data_log.delete();
        stop_log.delete();
        busy_log.delete();
        done_log.delete();
        rdy_log.delete();
    endtask

    // Launch one job and log until done is seen or the budget runs out.
    // mode 0: in_valid always 1; mode 1: in_valid 1 on even log cycles.
    // in_data = base + current cycle index. spam re-asserts start with other
    // lengths on cycle 1 and during the DONE cycle.
    task automatic run_job(input logic [7:0] al, input logic [7:0] no, input int mode,
                           input logic [31:0] base, input bit spam, input int budget,
                           output bit timed_out);
        int cyc;
        clear_logs();
        bus.acc_len  = al;
        bus.num_out  = no;
        bus.in_valid = 1'b0;
        bus.start    = 1'b1;
        tick();
        bus.start = 1'b0;
        if (spam) begin
            bus.acc_len = 8'd7;
            bus.num_out = 8'd7;
        end
        timed_out = 1'b1;
        for (int n = 0; n < budget; n++) begin
            cyc          = sig_log.size() - 1;
            bus.in_valid = (mode == 0) ? 1'b1 : ((cyc % 2) == 0);
            bus.in_data  = base + cyc;
            bus.start    = spam && ((cyc == 1) || (sig_log[cyc] == 3'b100));
            tick();
            if (done_log[sig_log.size() - 1]) begin
                timed_out = 1'b0;
                break;
            end
        end
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        bus.start    = 1'b0;
        bus.acc_len  = '0;
        bus.num_out  = '0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        rst = 1'b0;
        repeat (3) tick();
        assertions++;
        if ({bus.sig, bus.data, bus.isStop, bus.in_ready, bus.busy, bus.done} !== 38'd0) begin
            failures++;
            $display("FAIL reset_values: got sig=%0d data=%0h stop=%0b rdy=%0b busy=%0b done=%0b, want all 0",
                     bus.sig, bus.data, bus.isStop, bus.in_ready, bus.busy, bus.done);
        end
        rst = 1'b1;
        repeat (2) tick();
        assertions++;
        if ({bus.sig, bus.in_ready, bus.busy, bus.done} !== 6'd0) begin
            failures++;
            $display("FAIL idle_after_reset: got sig=%0d rdy=%0b busy=%0b done=%0b, want all 0",
                     bus.sig, bus.in_ready, bus.busy, bus.done);
        end
    endtask

    task automatic test_basic();
        int es [9] = '{0, 3, 5, 1, 1, 1, 2, 4, 0};
        int ed [9] = '{0, 0, 0, 5, 6, 7, 0, 0, 0};
        bit to;
        int busy_cnt;
        logic [37:0] o, w;
        run_job(8'd3, 8'd1, 0, 32'd3, 1'b0, 40, to);
        assertions++;
        if (to !== 1'b0 || sig_log.size() != 9) begin
            failures++;
            $display("FAIL basic_length: got timeout=%0b entries=%0d, want timeout=0 entries=9", to, sig_log.size());
        end
        for (int i = 0; i < 9 && i < sig_log.size(); i++) begin
            o = obs(i);
            w = want(es[i], i, 9, ed[i]);
            assertions++;
            if (o !== w) begin
                failures++;
                $display("FAIL basic cyc %0d: got %s, want %s", i, fmt(o), fmt(w));
            end
        end
        busy_cnt = 0;
        foreach (busy_log[i]) if (busy_log[i]) busy_cnt++;
        assertions++;
        if (busy_cnt != 8) begin
            failures++;
            $display("FAIL basic_busy_cycles: got %0d, want 8", busy_cnt);
        end
    endtask

    task automatic test_backpressure();
        int es [15] = '{0, 3, 5, 1, 0, 1, 2, 5, 0, 1, 0, 1, 2, 4, 0};
        int ed [15] = '{0, 0, 0, 22, 0, 24, 0, 0, 0, 28, 0, 30, 0, 0, 0};
        logic er [15] = '{0, 0, 1, 1, 1, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};
        bit to;
        int acc_cnt;
        logic [37:0] o, w;
        run_job(8'd2, 8'd2, 1, 32'd20, 1'b0, 60, to);
        assertions++;
        if (to !== 1'b0 || sig_log.size() != 15) begin
            failures++;
            $display("FAIL bp_length: got timeout=%0b entries=%0d, want timeout=0 entries=15", to, sig_log.size());
        end
        for (int i = 0; i < 15 && i < sig_log.size(); i++) begin
            o = obs(i);
            w = want(es[i], i, 15, ed[i]);
            assertions++;
            if (o !== w) begin
                failures++;
                $display("FAIL bp cyc %0d: got %s, want %s", i, fmt(o), fmt(w));
            end
            assertions++;
            if (rdy_log[i] !== er[i]) begin
                failures++;
                $display("FAIL bp_in_ready cyc %0d: got %0b, want %0b", i, rdy_log[i], er[i]);
            end
        end
        acc_cnt = 0;
        foreach (sig_log[i]) if (sig_log[i] == 3'b001) acc_cnt++;
        assertions++;
        if (acc_cnt != 4) begin
            failures++;
            $display("FAIL bp_handshakes: got %0d, want 4", acc_cnt);
        end
    endtask

    task automatic test_zero_lengths();
        int es0 [3] = '{0, 4, 0};
        int es1 [6] = '{0, 3, 2, 2, 4, 0};
        bit to;
        logic [37:0] o, w;
        run_job(8'd3, 8'd0, 0, 32'd100, 1'b0, 20, to);
        assertions++;
        if (to !== 1'b0 || sig_log.size() != 3) begin
            failures++;
            $display("FAIL zero_out_length: got timeout=%0b entries=%0d, want timeout=0 entries=3", to, sig_log.size());
        end
        for (int i = 0; i < 3 && i < sig_log.size(); i++) begin
            o = obs(i);
            w = want(es0[i], i, 3, 32'd0);
            assertions++;
            if (o !== w) begin
                failures++;
                $display("FAIL zero_out cyc %0d: got %s, want %s", i, fmt(o), fmt(w));
            end
        end
        run_job(8'd0, 8'd2, 0, 32'd200, 1'b0, 20, to);
        assertions++;
        if (to !== 1'b0 || sig_log.size() != 6) begin
            failures++;
            $display("FAIL zero_acc_length: got timeout=%0b entries=%0d, want timeout=0 entries=6", to, sig_log.size());
        end
        for (int i = 0; i < 6 && i < sig_log.size(); i++) begin
            o = obs(i);
            w = want(es1[i], i, 6, 32'd0);
            assertions++;
            if (o !== w) begin
                failures++;
                $display("FAIL zero_acc cyc %0d: got %s, want %s", i, fmt(o), fmt(w));
            end
        end
    endtask

    task automatic test_reset_mid_acc();
        int es [9] = '{0, 3, 5, 1, 1, 1, 2, 4, 0};
        int ed [9] = '{0, 0, 0, 5, 6, 7, 0, 0, 0};
        bit to;
        logic [37:0] o, w;
        clear_logs();
        bus.acc_len  = 8'd3;
        bus.num_out  = 8'd1;
        bus.in_valid = 1'b0;
        bus.start    = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        assertions++;
        if (bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL mid_reset_in_acc: got in_ready=%0b, want 1", bus.in_ready);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = 32'd99;
        tick();
        assertions++;
        if (bus.sig !== 3'b001 || bus.data !== 32'd99) begin
            failures++;
            $display("FAIL mid_reset_handshake: got sig=%0d data=%0h, want sig=1 data=63", bus.sig, bus.data);
        end
        bus.in_valid = 1'b0;
        rst = 1'b0;
        tick();
        assertions++;
        if ({bus.sig, bus.data, bus.isStop, bus.in_ready, bus.busy, bus.done} !== 38'd0) begin
            failures++;
            $display("FAIL mid_reset_values: got sig=%0d data=%0h stop=%0b rdy=%0b busy=%0b, want all 0",
                     bus.sig, bus.data, bus.isStop, bus.in_ready, bus.busy);
        end
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            assertions++;
            if (bus.sig !== 3'b000 || bus.isStop !== 1'b0 || bus.busy !== 1'b0) begin
                failures++;
                $display("FAIL mid_reset_quiet %0d: got sig=%0d stop=%0b busy=%0b, want 0 0 0",
                         k, bus.sig, bus.isStop, bus.busy);
            end
        end
        run_job(8'd3, 8'd1, 0, 32'd3, 1'b0, 40, to);
        assertions++;
        if (to !== 1'b0 || sig_log.size() != 9) begin
            failures++;
            $display("FAIL mid_reset_rerun_length: got timeout=%0b entries=%0d, want timeout=0 entries=9", to, sig_log.size());
        end
        for (int i = 0; i < 9 && i < sig_log.size(); i++) begin
            o = obs(i);
            w = want(es[i], i, 9, ed[i]);
            assertions++;
            if (o !== w) begin
                failures++;
                $display("FAIL mid_reset_rerun cyc %0d: got %s, want %s", i, fmt(o), fmt(w));
            end
        end
    endtask

    task automatic test_start_ignored();
        int es0 [8] = '{0, 3, 5, 1, 1, 2, 4, 0};
        int ed0 [8] = '{0, 0, 0, 42, 43, 0, 0, 0};
        int es1 [5] = '{0, 3, 2, 4, 0};
        bit to;
        logic [37:0] o, w;
        run_job(8'd2, 8'd1, 0, 32'd40, 1'b1, 40, to);
        assertions++;
        if (to !== 1'b0 || sig_log.size() != 8) begin
            failures++;
            $display("FAIL ignore_length: got timeout=%0b entries=%0d, want timeout=0 entries=8", to, sig_log.size());
        end
        for (int i = 0; i < 8 && i < sig_log.size(); i++) begin
            o = obs(i);
            w = want(es0[i], i, 8, ed0[i]);
            assertions++;
            if (o !== w) begin
                failures++;
                $display("FAIL ignore cyc %0d: got %s, want %s", i, fmt(o), fmt(w));
            end
        end
        // Launched in the cycle where done is high: must be accepted.
        run_job(8'd0, 8'd1, 0, 32'd0, 1'b0, 20, to);
        assertions++;
        if (to !== 1'b0 || sig_log.size() != 5) begin
            failures++;
            $display("FAIL after_done_length: got timeout=%0b entries=%0d, want timeout=0 entries=5", to, sig_log.size());
        end
        for (int i = 0; i < 5 && i < sig_log.size(); i++) begin
            o = obs(i);
            w = want(es1[i], i, 5, 32'd0);
            assertions++;
            if (o !== w) begin
                failures++;
                $display("FAIL after_done cyc %0d: got %s, want %s", i, fmt(o), fmt(w));
            end
        end
    endtask

    task automatic test_max_count();
        localparam logic [31:0] BASE = 32'h1000_0000;
        bit to;
        int acc_cnt;
        int s;
        logic [31:0] d;
        logic [37:0] o, w;
        run_job(8'd255, 8'd1, 0, BASE, 1'b0, 400, to);
        assertions++;
        if (to !== 1'b0 || sig_log.size() != 261) begin
            failures++;
            $display("FAIL max_length: got timeout=%0b entries=%0d, want timeout=0 entries=261", to, sig_log.size());
        end
        for (int i = 0; i < 261 && i < sig_log.size(); i++) begin
            d = '0;
            if (i == 0)        s = 0;
            else if (i == 1)   s = 3;
            else if (i == 2)   s = 5;
            else if (i <= 257) begin s = 1; d = BASE + i - 1; end
            else if (i == 258) s = 2;
            else if (i == 259) s = 4;
            else               s = 0;
            o = obs(i);
            w = want(s, i, 261, d);
            assertions++;
            if (o !== w) begin
                failures++;
                $display("FAIL max cyc %0d: got %s, want %s", i, fmt(o), fmt(w));
            end
        end
        acc_cnt = 0;
        foreach (sig_log[i]) if (sig_log[i] == 3'b001) acc_cnt++;
        assertions++;
        if (acc_cnt != 255) begin
            failures++;
            $display("FAIL max_acc_count: got %0d, want 255", acc_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_zero_lengths();
        test_reset_mid_acc();
        test_start_ignored();
        test_max_count();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end
endmodule

// File: doc/acc_issue.md
Name: acc_issue

Overview:
- Issue sequencer that drives the control/data stream into the output accumulator.
- Takes a job descriptor: num_out result words, each the sum of acc_len partial sums.
- Accepts partial sums from the compute array over a valid/ready handshake.
- Emits the sig/data/isStop command sequence that frames and accumulates them.

Parameters:
DATA_W, 32, width of partial-sum data and the data output
CNT_W, 8, width of the acc_len and num_out counters

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  reset, synchronous, active-low
start  input  1  one-cycle job start request; sampled only in IDLE
acc_len  input  CNT_W  partial sums per output word; latched on accepted start
num_out  input  CNT_W  output words per job; latched on accepted start
in_valid  input  1  partial sum available on in_data
in_data  input  DATA_W  partial sum from the compute array
in_ready  output  1  issuer accepts in_data this cycle
sig  output  3  command to accumulator: 000 NOP, 001 ACC, 010 OUT, 011 CAT_START, 100 CAT_END, 101 CLR
data  output  DATA_W  operand accompanying ACC; 0 for all other commands
isStop  output  1  high only in the cycle sig=100 (last command of a job)
busy  output  1  high from accepted start until DONE completes
done  output  1  one-cycle pulse after CAT_END is issued

Behaviour:
- Reset (rst=0 at a clock edge) forces the following values. This applies also mid-job, aborting it with no CAT_END issued:
  - state = IDLE
  - sig = 000, data = 0
  - isStop = 0, in_ready = 0, busy = 0, done = 0
  - counters = 0
- sig, data, isStop, busy and done are registered.
- in_ready is combinational from state: 1 only in ACC.
- States and transitions:
  - IDLE: when start=1, latch acc_len and num_out, set busy=1.
    - If num_out=0, go to END.
    - Otherwise go to CATS.
    - start while not IDLE is ignored.
  - CATS: issue sig=011 for one cycle.
    - If acc_len=0, go to OUT.
    - Otherwise go to CLR.
  - CLR: issue sig=101 for one cycle, reset the sum counter to 0, go to ACC.
  - ACC: a handshake occurs when in_valid=1 and in_ready=1.
    - On a handshake: issue sig=001 with data=in_data and increment the sum counter.
    - After the handshake where the sum counter reaches acc_len-1, go to OUT.
    - When in_valid=0: issue sig=000, data=0, and stay in ACC.
  - OUT: issue sig=010 for one cycle and increment the output counter.
    - If the output counter reaches num_out, go to END.
    - Otherwise, if acc_len=0, go to OUT again with no CLR/ACC (zero-length words).
    - Otherwise go to CLR.
  - END: issue sig=100 with isStop=1 for one cycle, go to DONE.
  - DONE: set done=1 and busy=0 for one cycle, go to IDLE.
- Timing:
  - Latency: start sampled at edge N gives sig=011 visible after edge N+1.
  - One command per cycle.
  - Job length with no stalls (num_out>0) = 2 + num_out*(acc_len+1+(acc_len>0)) + 1 cycles from the CATS cycle through the DONE cycle.
- Arithmetic: counters are CNT_W wide and compare against latched values, so acc_len=2^CNT_W-1 is legal. Data is passed through unchanged; the issuer performs no summation.
- Simultaneous events:
  - In the DONE cycle start is ignored, because the machine is not IDLE.
  - A start on the cycle after DONE is accepted.
- Between commands, and in IDLE, sig=000.

Test Plan:
- Basic job, acc_len=3, num_out=1, in_valid held 1, in_data=5,6,7:
  - Required sig stream: 011,101,001(5),001(6),001(7),010,100.
  - isStop=1 only on the 100 cycle, done pulses the next cycle, busy high for 8 cycles.
- Backpressure, acc_len=2, num_out=2, in_valid toggling 1,0,1,0,...:
  - Required: 000 NOP cycles interleave between the ACC commands.
  - Exactly 4 handshakes, sig sequence 011,101,ACC,ACC,010,101,ACC,ACC,010,100.
  - in_ready=0 outside ACC.
- Zero lengths:
  - num_out=0 gives 011 never; 100 comes one cycle after start, then done.
  - acc_len=0, num_out=2 gives 011,010,010,100.
- Reset mid-ACC (rst=0 after 1 handshake): next cycle sig=000, busy=0, in_ready=0, no 100 issued; a new start=1 then runs a clean job.
- start pulsed during busy and during the DONE cycle: ignored, with no change to latched acc_len/num_out. A start on the cycle after done is accepted.
- Max count, CNT_W=8, acc_len=255, num_out=1: exactly 255 ACC commands before 010, with no counter wrap.
